// File: rtl/spi_slave_regctrl.sv
// ============================================================================
// Module      : spi_slave_regctrl
// Description : Frames the spi_slave bit stream into command/data bytes and
//               drives an addressed register bus with read pre-fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_regctrl #(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int DUMMY_BYTES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_ss,
    input  logic [WIDTH-1:0]      rx_data,
    input  logic [2:0]            rx_bitcnt,
    input  logic                  rx_valid,
    output logic [WIDTH-1:0]      tx_data,
    input  logic                  tx_load,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [WIDTH-1:0]      reg_wdata,
    output logic                  reg_wen,
    output logic                  reg_ren,
    input  logic [WIDTH-1:0]      reg_rdata,
    input  logic                  reg_rvalid,
    output logic                  busy,
    output logic                  err_underrun,
    input  logic                  err_clr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WR    = 3'd2,
        ST_DUMMY = 3'd3,
        ST_RD    = 3'd4
    } state_t;

    localparam logic [2:0] c_last_bit   = 3'(WIDTH - 1);
    localparam logic [1:0] c_dummy_last = 2'(DUMMY_BYTES - 1);

    state_t                r_state, w_state_n;
    logic                  r_ss_d;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_n;
    logic [WIDTH-1:0]      r_wdata, w_wdata_n;
    logic                  r_wen,   w_wen_n;
    logic                  r_ren,   w_ren_n;
    logic [WIDTH-1:0]      r_tx,    w_tx_n;
    logic [WIDTH-1:0]      r_rbuf,  w_rbuf_n;
    logic                  r_full,  w_full_n;
    logic                  r_pend,  w_pend_n;
    logic                  r_drop,  w_drop_n;
    logic                  r_fetch, w_fetch_n;
    logic [1:0]            r_dcnt,  w_dcnt_n;
    logic                  r_err,   w_err_n;

    logic w_word;
    logic w_ss_fall;
    logic w_rv;
    logic w_issue;
    logic w_under;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ss_d  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_tx    <= '0;
            r_rbuf  <= '0;
            r_full  <= 1'b0;
            r_pend  <= 1'b0;
            r_drop  <= 1'b0;
            r_fetch <= 1'b0;
            r_dcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ss_d  <= rx_ss;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_wen   <= w_wen_n;
            r_ren   <= w_ren_n;
            r_tx    <= w_tx_n;
            r_rbuf  <= w_rbuf_n;
            r_full  <= w_full_n;
            r_pend  <= w_pend_n;
            r_drop  <= w_drop_n;
            r_fetch <= w_fetch_n;
            r_dcnt  <= w_dcnt_n;
            r_err   <= w_err_n;
        end
    end

    // r_ss_d resets low so a frame already running at reset release is not joined
    assign w_word    = rx_valid && (rx_bitcnt == c_last_bit);
    assign w_ss_fall = r_ss_d && !rx_ss;
    assign w_rv      = reg_rvalid && r_pend;

    always_comb begin
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_wen_n   = 1'b0;
        w_ren_n   = 1'b0;
        w_rbuf_n  = r_rbuf;
        w_full_n  = r_full;
        w_pend_n  = r_pend;
        w_drop_n  = r_drop;
        w_fetch_n = r_fetch;
        w_dcnt_n  = r_dcnt;
        w_issue   = 1'b0;
        w_under   = 1'b0;

        // address advances after the write strobe so it is stable during it
        if (r_wen) begin
            w_addr_n = r_addr + ADDR_WIDTH'(1);
        end

        // data arriving with a tx_load, or for an address already skipped, is dropped
        if (w_rv) begin
            w_pend_n = 1'b0;
            w_drop_n = 1'b0;
            if (!r_drop && !(tx_load && r_state == ST_RD)) begin
                w_rbuf_n = reg_rdata;
                w_full_n = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_n = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_word) begin
                    w_addr_n = rx_data[ADDR_WIDTH-1:0];
                    if (rx_data[WIDTH-1]) begin
                        w_issue   = 1'b1;
                        w_dcnt_n  = '0;
                        w_state_n = (DUMMY_BYTES == 0) ? ST_RD : ST_DUMMY;
                    end else begin
                        w_state_n = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (w_word) begin
                    w_wdata_n = rx_data;
                    w_wen_n   = 1'b1;
                end
            end
            ST_DUMMY: begin
                if (w_word) begin
                    if (r_dcnt == c_dummy_last) begin
                        w_state_n = ST_RD;
                    end else begin
                        w_dcnt_n = r_dcnt + 2'd1;
                    end
                end
            end
            ST_RD: begin
                if (tx_load) begin
                    w_under  = !r_full;
                    w_full_n = 1'b0;
                    w_addr_n = r_addr + ADDR_WIDTH'(1);
                    if (!r_pend || w_rv) begin
                        w_issue = 1'b1;
                    end else begin
                        w_fetch_n = 1'b1;
                        w_drop_n  = 1'b1;
                    end
                end else if (r_fetch && (!r_pend || w_rv)) begin
                    w_issue = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_issue) begin
            w_ren_n   = 1'b1;
            w_pend_n  = 1'b1;
            w_fetch_n = 1'b0;
            w_rbuf_n  = '1;
            w_full_n  = 1'b0;
        end

        // deselect aborts the frame; a partial byte never produced a strobe
        if (r_state != ST_IDLE && rx_ss) begin
            w_state_n = ST_IDLE;
            w_wen_n   = 1'b0;
            w_ren_n   = 1'b0;
            w_pend_n  = 1'b0;
            w_full_n  = 1'b0;
            w_drop_n  = 1'b0;
            w_fetch_n = 1'b0;
        end

        w_err_n = (r_err && !err_clr) || w_under;
        w_tx_n  = (w_state_n == ST_RD) ? w_rbuf_n : '0;
    end

    assign tx_data      = r_tx;
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign reg_wen      = r_wen;
    assign reg_ren      = r_ren;
    assign busy         = (r_state != ST_IDLE);
    assign err_underrun = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_regctrl.sv
// ============================================================================
// Module      : tb_spi_slave_regctrl
// Description : Directed bench for spi_slave_regctrl with a cycle-level
//               spi_slave stand-in and a variable-latency register model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_regctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ss = 1'b1;
    logic [7:0] rx_data = '0;
    logic [2:0] rx_bitcnt = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_load = 1'b0;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wen;
    logic       reg_ren;
    logic [7:0] reg_rdata = '0;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic       err_underrun;
    logic       err_clr = 1'b0;

    spi_slave_regctrl #(.WIDTH(8), .ADDR_WIDTH(7), .DUMMY_BYTES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_ss        (rx_ss),
        .rx_data      (rx_data),
        .rx_bitcnt    (rx_bitcnt),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wen      (reg_wen),
        .reg_ren      (reg_ren),
        .reg_rdata    (reg_rdata),
        .reg_rvalid   (reg_rvalid),
        .busy         (busy),
        .err_underrun (err_underrun),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [14:0] wq[$];
    logic [6:0]  rq[$];

    int         lat = 2;
    int         cnt = 0;
    logic [6:0] paddr = '0;

    always @(negedge clk) begin
        if (reg_wen) wq.push_back({reg_addr, reg_wdata});
        if (reg_ren) rq.push_back(reg_addr);
    end

    // register file stand-in: one read in flight, returns addr+0x40 after lat cycles
    always @(negedge clk) begin
        reg_rvalid = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                reg_rvalid = 1'b1;
                reg_rdata  = {1'b0, paddr} + 8'h40;
            end
        end
        if (reg_ren) begin
            cnt   = lat;
            paddr = reg_addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] b, input int nbits, output logic [7:0] miso);
        logic [7:0] sh;
        sh      = '0;
        tx_load = 1'b1;
        miso    = tx_data;
        @(negedge clk);
        tx_load = 1'b0;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            sh        = {sh[6:0], b[7-i]};
            rx_data   = sh;
            rx_bitcnt = 3'(i);
            rx_valid  = 1'b1;
            @(negedge clk);
            rx_valid  = 1'b0;
            tick(3);
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] a0;
        logic [7:0] e0;
        logic [6:0] a1;
        logic [7:0] e1;
    } wvec_t;

    wvec_t      wv[3];
    logic [7:0] m0, m1, m2, m3;

    initial begin
        wv[0] = '{8'h05, 8'h11, 8'h22, 7'h05, 8'h11, 7'h06, 8'h22};
        wv[1] = '{8'h7F, 8'hAA, 8'hBB, 7'h7F, 8'hAA, 7'h00, 8'hBB};
        wv[2] = '{8'h40, 8'h5A, 8'hC3, 7'h40, 8'h5A, 7'h41, 8'hC3};

        tick(3);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_reg_addr", reg_addr, 7'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        chk("rst_reg_wen", reg_wen, 1'b0);
        chk("rst_reg_ren", reg_ren, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_underrun, 1'b0);
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            wq.delete();
            rx_ss = 1'b0;
            @(negedge clk);
            chk($sformatf("wr%0d_busy_rise", v), busy, 1'b1);
            tick(1);
            send_word(wv[v].cmd, 8, m0);
            send_word(wv[v].d0, 8, m1);
            send_word(wv[v].d1, 8, m2);
            chk($sformatf("wr%0d_miso", v), m2, 8'h00);
            rx_ss = 1'b1;
            @(negedge clk);
            chk($sformatf("wr%0d_busy_fall", v), busy, 1'b0);
            tick(1);
            chk($sformatf("wr%0d_nwrites", v), wq.size(), 2);
            if (wq.size() == 2) begin
                chk($sformatf("wr%0d_w0", v), wq[0], {wv[v].a0, wv[v].e0});
                chk($sformatf("wr%0d_w1", v), wq[1], {wv[v].a1, wv[v].e1});
            end
        end

        // read frame, 2-cycle register latency
        lat = 2;
        rq.delete();
        rx_ss = 1'b0;
        tick(2);
        send_word(8'h85, 8, m0);
        send_word(8'h00, 8, m1);
        send_word(8'h00, 8, m2);
        send_word(8'h00, 8, m3);
        rx_ss = 1'b1;
        tick(2);
        chk("rd_miso0", m0, 8'h00);
        chk("rd_miso1", m1, 8'h00);
        chk("rd_miso2", m2, 8'h45);
        chk("rd_miso3", m3, 8'h46);
        chk("rd_nren", rq.size(), 3);
        if (rq.size() == 3) begin
            chk("rd_ren0", rq[0], 7'h05);
            chk("rd_ren1", rq[1], 7'h06);
            chk("rd_ren2", rq[2], 7'h07);
        end
        chk("rd_err", err_underrun, 1'b0);
        chk("rd_tx_idle", tx_data, 8'h00);

        // register data withheld past the first data tx_load
        lat = 60;
        rx_ss = 1'b0;
        tick(2);
        send_word(8'h90, 8, m0);
        send_word(8'h00, 8, m1);
        send_word(8'h00, 8, m2);
        chk("ur_miso", m2, 8'hFF);
        chk("ur_err_set", err_underrun, 1'b1);
        rx_ss = 1'b1;
        tick(2);
        chk("ur_err_sticky", err_underrun, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ur_err_clr", err_underrun, 1'b0);
        tick(130);
        chk("ur_late_tx", tx_data, 8'h00);

        // deselect after 5 bits of a data byte
        lat = 2;
        wq.delete();
        rx_ss = 1'b0;
        tick(2);
        send_word(8'h02, 8, m0);
        send_word(8'h77, 5, m1);
        rx_ss = 1'b1;
        @(negedge clk);
        chk("ab_busy", busy, 1'b0);
        tick(3);
        chk("ab_nwrites", wq.size(), 0);
        rx_ss = 1'b0;
        tick(2);
        send_word(8'h01, 8, m0);
        send_word(8'h33, 8, m1);
        rx_ss = 1'b1;
        tick(2);
        chk("ab_next_nwrites", wq.size(), 1);
        if (wq.size() == 1) chk("ab_next_w0", wq[0], {7'h01, 8'h33});

        // reset in the middle of a read frame with a read outstanding
        lat = 10;
        rx_ss = 1'b0;
        tick(2);
        send_word(8'hA0, 8, m0);
        chk("rs_pre_addr", reg_addr, 7'h20);
        rst = 1'b1;
        #1;
        chk("rs_tx_data", tx_data, 8'h00);
        chk("rs_reg_addr", reg_addr, 7'h00);
        chk("rs_reg_wdata", reg_wdata, 8'h00);
        chk("rs_reg_wen", reg_wen, 1'b0);
        chk("rs_reg_ren", reg_ren, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_err", err_underrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(15);
        chk("rs_late_tx", tx_data, 8'h00);
        chk("rs_no_join", busy, 1'b0);
        rx_ss = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_slave_regctrl.md
# spi_slave_regctrl

Register-access controller that sequences the `spi_slave` bit-level datapath into a simple addressed register bus. It frames the per-bit rx stream into command and data bytes and decodes read/write commands with auto-incrementing address. It issues single-cycle register strobes and pre-fetches read data into `tx_data` ahead of each `tx_load`. It sits between `spi_slave` and the block's control/status register file.

## Interface
- `WIDTH`, 8: SPI word width; fixed at 8, matching `spi_slave` `WIDTH`.
- `ADDR_WIDTH`, 7: register address width; must equal `WIDTH-1`.
- `DUMMY_BYTES`, 1: dummy words between command and first read data (0..3).

Ports (`name  direction  width  meaning`):
- `clk`  in  1  system clock, shared with `spi_slave`.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_ss`  in  1  slave select from `spi_slave`; low = selected.
- `rx_data`  in  8  shift register contents, MSB first.
- `rx_bitcnt`  in  3  index of the bit just received (0..7).
- `rx_valid`  in  1  one-cycle pulse per received bit.
- `tx_data`  out  8  next word for `spi_slave`, registered.
- `tx_load`  in  1  one-cycle pulse when `spi_slave` samples `tx_data` (start of each word).
- `reg_addr`  out  7  register address.
- `reg_wdata`  out  8  write data.
- `reg_wen`  out  1  one-cycle write strobe.
- `reg_ren`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid with `reg_rvalid`.
- `reg_rvalid`  in  1  read-data strobe; any latency ≥1 cycle after `reg_ren`.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `err_underrun`  out  1  sticky: `tx_load` arrived with no read data ready.
- `err_clr`  in  1  clears `err_underrun`.

## Operation
- Word complete: `rx_valid && rx_bitcnt==7`; the full byte is in `rx_data` that cycle.
- Frame: byte0 is the command `{rw, addr[6:0]}`, where `rw=1` is a read. Following bytes are data. The address increments after every data byte and wraps from 0x7F to 0x00.
- States: IDLE, CMD, WR, DUMMY, RD.
  - IDLE→CMD: `rx_ss` falls.
  - CMD, word complete: latch `addr`. If `rw=0`, go to WR. If `rw=1`, issue `reg_ren` and go to DUMMY, or RD if `DUMMY_BYTES=0`.
  - WR, each word complete: `reg_wdata<=rx_data`, pulse `reg_wen` at current `reg_addr`, then increment the address.
  - DUMMY: count `DUMMY_BYTES` word completes, then go to RD.
  - RD, each `tx_load`: data word is consumed. Increment the address, then issue the next `reg_ren` (pre-fetch).
  - Any state, `rx_ss` high: go to IDLE. A partial byte is discarded, with no strobe.
- Read buffer: at most one read outstanding, and `reg_ren` is never issued while one is pending.
  - On `reg_rvalid`, `tx_data<=reg_rdata` and the buffer is marked full.
  - `tx_load` with the buffer empty while in RD sets `err_underrun`. The word sent is 0xFF, since `tx_data` is preset to 0xFF on every `reg_ren`.
- `tx_data` is 0x00 in IDLE, CMD, WR and DUMMY.
- `reg_rvalid` arriving after the frame ends, or with no read outstanding, is ignored.
- `err_clr` and a new underrun in the same cycle: the flag stays set.

## Timing
- Reset value of every output is 0: `tx_data`, `reg_addr`, `reg_wdata`, `reg_wen`, `reg_ren`, `busy`, `err_underrun`. State is IDLE.
- Reset mid-frame returns to IDLE immediately. After reset release, the FSM waits for the next `rx_ss` falling edge; it does not join a frame already in progress.
- `reg_wen` asserts 1 cycle after the word-complete cycle. `reg_addr` and `reg_wdata` are stable in the strobe cycle.
- The first `reg_ren` asserts 1 cycle after the command word completes. Each pre-fetch `reg_ren` asserts 1 cycle after `tx_load`, using the incremented address.
- `tx_data` updates 1 cycle after `reg_rvalid`.
- `reg_rvalid` in the same cycle as `tx_load` counts as an underrun; that late data is dropped.
- Register latency budget is the time from `reg_ren` to the next `tx_load`, minus 1 clk: (`DUMMY_BYTES`×8 SCK periods) for the first read, 8 SCK periods for each later read.
- `busy` rises 1 cycle after `rx_ss` falls and clears 1 cycle after `rx_ss` rises.

## Test plan
- Write frame 0x05,0x11,0x22 → `reg_wen` twice: addr 0x05 data 0x11, then addr 0x06 data 0x22; `busy` drops after SS rises.
- Read frame 0x85,dummy,x,x with a 2-cycle `reg_rvalid` register model returning addr+0x40 → MISO shows 0x00,0x00,0x45,0x46; `reg_ren` for addrs 0x05, 0x06 and 0x07; `err_underrun`=0.
- Write at 0x7F with 2 data bytes 0xAA,0xBB → writes to 0x7F then 0x00.
- Read with `reg_rvalid` withheld past the first data `tx_load` → 0xFF sent and `err_underrun`=1; pulse `err_clr` → 0.
- SS deasserted after 5 bits of a write data byte → no `reg_wen`, state IDLE; the next frame 0x01,0x33 writes addr 0x01.
- `rst` asserted mid read frame → all outputs 0 at once; a late `reg_rvalid` is ignored and `tx_data` stays 0x00.
